// File: rtl/reg_bank_pkg.sv
// Shared definitions for the banked register file and its scoreboard.
//   bw_of/rw_of   : bank-select and index widths derived from bank/register counts
//   ZERO_BANK/IDX : location of the hardwired zero register
//   reg_addr_t    : {bank,index} address for the default configuration
//   is_zero_reg   : true when an address names the hardwired zero register
package reg_bank_pkg;

  localparam int unsigned ZERO_BANK = 0;
  localparam int unsigned ZERO_IDX  = 0;

  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned DEF_NBANK = 2;

  function automatic int unsigned bw_of(input int unsigned nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

  function automatic int unsigned rw_of(input int unsigned nreg);
    return $clog2(nreg);
  endfunction

  localparam int unsigned DEF_BW = bw_of(DEF_NBANK);
  localparam int unsigned DEF_RW = rw_of(DEF_NREG);

  typedef struct packed {
    logic [DEF_BW-1:0] bank;
    logic [DEF_RW-1:0] index;
  } reg_addr_t;

  function automatic logic is_zero_reg(input int unsigned bank, input int unsigned idx);
    return (bank == ZERO_BANK) && (idx == ZERO_IDX);
  endfunction

endpackage

// File: rtl/sb_table.sv
// Busy-bit table with a running popcount.
//   clk_i, rst_ni : clock, async active-low reset
//   set_i/set_addr_i : mark {bank,index} pending at the next edge (set wins over clear)
//   clr_i/clr_addr_i : clear {bank,index} at the next edge
//   qry_addr_i    : NRP packed {bank,index} query addresses
//   qry_busy_o    : registered busy bit for each query address
//   cnt_o         : number of busy bits currently set
// Strobes arrive pre-filtered: zero register and out-of-range banks never reach here.
module sb_table #(
  parameter int unsigned NRP = 2,
  parameter int unsigned BW  = 1,
  parameter int unsigned RW  = 5,
  parameter int unsigned CW  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [BW+RW-1:0]      set_addr_i,
  input  logic                  clr_i,
  input  logic [BW+RW-1:0]      clr_addr_i,
  input  logic [NRP*(BW+RW)-1:0] qry_addr_i,
  output logic [NRP-1:0]        qry_busy_o,
  output logic [CW-1:0]         cnt_o
);

  localparam int unsigned AW    = BW + RW;
  localparam int unsigned NSLOT = 1 << AW;

  logic [NSLOT-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inc, dec;

  always_comb begin
    busy_d = busy_q;
    // Count only real transitions so the counter tracks the popcount exactly.
    inc = set_i && !busy_q[set_addr_i];
    dec = clr_i && busy_q[clr_addr_i] && !(set_i && (set_addr_i == clr_addr_i));
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_qry
    assign qry_busy_o[i] = busy_q[qry_addr_i[i*AW +: AW]];
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_bank_sb.sv
// Multi-bank register file with integrated scoreboard.
//   clk_i, rst_ni          : clock, async active-low reset
//   rd_gof_i/rd_num_i      : per-port bank/index (port i at [i*BW +: BW] / [i*RW +: RW])
//   rd_data_o/rd_busy_o    : per-port combinational data and pending flag
//   wr_en_i/wr_gof_i/wr_num_i/wr_data_i : write port; a write also clears the target busy bit
//   sb_set_i/sb_gof_i/sb_num_i : mark a register pending at the next edge
//   busy_cnt_o             : number of pending registers
//   dbg_num_i/dbg_data_o   : debug read {bank,index}, never forwarded
// Bank 0 index 0 is hardwired zero.
// Build option REG_BYPASS_EN: same-cycle forwarding of write data onto read ports.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NBANK = 2,
  parameter int unsigned NRP   = 2,
  localparam int unsigned RW   = rw_of(NREG),
  localparam int unsigned BW   = bw_of(NBANK),
  localparam int unsigned CW   = $clog2(NBANK * NREG + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRP*BW-1:0]    rd_gof_i,
  input  logic [NRP*RW-1:0]    rd_num_i,
  output logic [NRP*WIDTH-1:0] rd_data_o,
  output logic [NRP-1:0]       rd_busy_o,
  input  logic                 wr_en_i,
  input  logic [BW-1:0]        wr_gof_i,
  input  logic [RW-1:0]        wr_num_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 sb_set_i,
  input  logic [BW-1:0]        sb_gof_i,
  input  logic [RW-1:0]        sb_num_i,
  output logic [CW-1:0]        busy_cnt_o,
  input  logic [BW+RW-1:0]     dbg_num_i,
  output logic [WIDTH-1:0]     dbg_data_o
);

  localparam int unsigned AW = BW + RW;

  logic [WIDTH-1:0] mem_q [NBANK][NREG];
  logic             wr_ok, sb_ok;
  logic [NRP*AW-1:0] qry_addr;
  logic [NRP-1:0]    qry_busy;

  // Zero register and nonexistent banks swallow both writes and scoreboard sets.
  always_comb begin
    wr_ok = wr_en_i && (32'(wr_gof_i) < NBANK) && !is_zero_reg(32'(wr_gof_i), 32'(wr_num_i));
    sb_ok = sb_set_i && (32'(sb_gof_i) < NBANK) && !is_zero_reg(32'(sb_gof_i), 32'(sb_num_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem_q[wr_gof_i][wr_num_i] <= wr_data_i;
    end
  end

  sb_table #(
    .NRP(NRP),
    .BW (BW),
    .RW (RW),
    .CW (CW)
  ) u_sb_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (sb_ok),
    .set_addr_i({sb_gof_i, sb_num_i}),
    .clr_i     (wr_ok),
    .clr_addr_i({wr_gof_i, wr_num_i}),
    .qry_addr_i(qry_addr),
    .qry_busy_o(qry_busy),
    .cnt_o     (busy_cnt_o)
  );

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [BW-1:0] gof;
    logic [RW-1:0] num;
    logic          hit_ok;

    assign gof    = rd_gof_i[i*BW +: BW];
    assign num    = rd_num_i[i*RW +: RW];
    assign qry_addr[i*AW +: AW] = {gof, num};
    assign hit_ok = (32'(gof) < NBANK) && !is_zero_reg(32'(gof), 32'(num));

`ifdef REG_BYPASS_EN
    logic wr_hit, sb_hit;
    assign wr_hit = wr_ok && ({gof, num} == {wr_gof_i, wr_num_i});
    assign sb_hit = sb_ok && ({gof, num} == {sb_gof_i, sb_num_i});
    // A forwarded write retires its producer unless a new one is issued this same cycle.
    assign rd_data_o[i*WIDTH +: WIDTH] = !hit_ok ? '0 : (wr_hit ? wr_data_i : mem_q[gof][num]);
    assign rd_busy_o[i] = hit_ok && (wr_hit ? sb_hit : qry_busy[i]);
`else
    assign rd_data_o[i*WIDTH +: WIDTH] = hit_ok ? mem_q[gof][num] : '0;
    assign rd_busy_o[i] = hit_ok && qry_busy[i];
`endif
  end

  logic [BW-1:0] dbg_gof;
  logic [RW-1:0] dbg_idx;
  assign dbg_gof = dbg_num_i[AW-1:RW];
  assign dbg_idx = dbg_num_i[RW-1:0];
  assign dbg_data_o = ((32'(dbg_gof) < NBANK) && !is_zero_reg(32'(dbg_gof), 32'(dbg_idx)))
                      ? mem_q[dbg_gof][dbg_idx] : '0;

endmodule
